box_sequence_plotter: RTL and testbench

Parametrised, table-driven box plotter for the VGA adapter write port. On a `start` request it walks a per-player coordinate table and paints a filled BOX_W×BOX_H block at every table point in a caller-supplied colour. It emits one pixel per cycle on `x`/`y`/`colour`/`plot`, honours a `stall` back-pressure input, and pulses `done` when finished. It serves both the player-track reset and redraw paths, for any number of players.

---
 rtl/pyon_plot_pkg.sv | 14 +
 rtl/point_table.sv | 25 ++
 rtl/box_sequence_plotter.sv | 93 +++++++++
 tb/tb_box_sequence_plotter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pyon_plot_pkg.sv
// pyon_plot_pkg: shared widths, colours, point-entry type and plotter state for the box plotter
package pyon_plot_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] COL_RED = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;
  localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
  typedef struct packed {
    logic [3:0] x_off;
    logic [Y_W-1:0] y;
  } point_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
endpackage

// File: rtl/point_table.sv
// point_table: combinational index to {x_off, y} lookup of the per-lane track points
module point_table
  import pyon_plot_pkg::*;
#(
  parameter int NUM_POINTS = 33,
  parameter int IW = 6
) (
  input  logic [IW-1:0] idx,
  output point_t        entry
);
  localparam int N = 33;
  localparam logic [Y_W-1:0] Y_TAB [N] = '{
    7'd4, 7'd13, 7'd19, 7'd22, 7'd25, 7'd31, 7'd37, 7'd49, 7'd58, 7'd61, 7'd67,
    7'd76, 7'd82, 7'd85, 7'd88, 7'd94, 7'd97,
    7'd7, 7'd10, 7'd16, 7'd28, 7'd34, 7'd40, 7'd43, 7'd46, 7'd52, 7'd55,
    7'd64, 7'd70, 7'd73, 7'd79, 7'd91, 7'd100
  };
  always_comb begin
    entry = '0;
    if (32'(idx) < N && 32'(idx) < NUM_POINTS) begin
      entry.x_off = (32'(idx) >= 17) ? 4'd5 : 4'd0;
      entry.y = Y_TAB[idx];
    end
  end
endmodule

// File: rtl/box_sequence_plotter.sv
// box_sequence_plotter: walks a lane's point table and paints a clipped BOX_W x BOX_H block per point
module box_sequence_plotter
  import pyon_plot_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_POINTS = 33,
  parameter int X_BASE = 38,
  parameter int PLAYER_PITCH = 80,
  parameter int BOX_W = 2,
  parameter int BOX_H = 2,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [PW-1:0]       player,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);
  localparam int IW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  state_t r_state;
  logic [IW-1:0] r_idx;
  logic [PW-1:0] r_player;
  logic [COLOUR_W-1:0] r_colour;
  logic [8:0] r_x0;
  logic [7:0] r_y0;
  logic [2:0] r_px, r_py;
  point_t w_entry;
  logic [8:0] w_x;
  logic [7:0] w_y;
  logic w_accept, w_step, w_clip, w_last_px, w_last_py, w_last_pt;
  point_table #(.NUM_POINTS(NUM_POINTS), .IW(IW)) u_table (.idx(r_idx), .entry(w_entry));
  assign w_x = r_x0 + 9'(r_px);
  assign w_y = r_y0 + 8'(r_py);
  assign w_accept = (r_state == S_IDLE) && start && (32'(player) < NUM_PLAYERS);
  assign w_step = (r_state == S_DRAW) && !stall;
  // Clipped pixels still consume a cycle so boxes truncate instead of wrapping.
  assign w_clip = (32'(w_x) >= SCREEN_W) || (32'(w_y) >= SCREEN_H);
  assign w_last_px = 32'(r_px) == BOX_W - 1;
  assign w_last_py = 32'(r_py) == BOX_H - 1;
  assign w_last_pt = 32'(r_idx) == NUM_POINTS - 1;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign plot = w_step && !w_clip;
  assign x = (r_state == S_DRAW) ? w_x[X_W-1:0] : '0;
  assign y = (r_state == S_DRAW) ? w_y[Y_W-1:0] : '0;
  assign colour = r_colour;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_player <= '0;
      r_colour <= '0;
      r_x0 <= '0;
      r_y0 <= '0;
      r_px <= '0;
      r_py <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_LOAD;
          r_idx <= '0;
          r_player <= player;
          r_colour <= colour_in;
        end
        S_LOAD: begin
          r_x0 <= 9'(X_BASE + PLAYER_PITCH * int'(r_player) + int'(w_entry.x_off));
          r_y0 <= 8'(w_entry.y);
          r_px <= '0;
          r_py <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW: if (w_step) begin
          r_px <= w_last_px ? 3'd0 : r_px + 3'd1;
          if (w_last_px) r_py <= w_last_py ? 3'd0 : r_py + 3'd1;
          if (w_last_px && w_last_py) begin
            r_state <= w_last_pt ? S_DONE : S_LOAD;
            if (!w_last_pt) r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_box_sequence_plotter.sv
// tb_box_sequence_plotter: table vectors, corner sequences and randomized stall runs against a timeline model
module tb_box_sequence_plotter;
  localparam int MAXC = 600;
  localparam int YT [33] = '{4, 13, 19, 22, 25, 31, 37, 49, 58, 61, 67, 76, 82, 85, 88, 94, 97,
                             7, 10, 16, 28, 34, 40, 43, 46, 52, 55, 64, 70, 73, 79, 91, 100};
  logic clk = 0, resetn = 0, start_d = 0, start_c = 0, stall = 0;
  logic [1:0] player = '0;
  logic [2:0] colour_in = '0;
  logic d_busy, d_done, d_plot, c_busy, c_done, c_plot;
  logic [7:0] d_x, c_x;
  logic [6:0] d_y, c_y;
  logic [2:0] d_colour, c_colour;
  int tests = 0, fails = 0;
  bit sarr [MAXC];
  bit starr [MAXC];
  int exp_busy [MAXC], exp_done [MAXC], exp_plot [MAXC], exp_xy [MAXC], exp_x [MAXC], exp_y [MAXC];
  int obs_busy [MAXC], obs_done [MAXC], obs_plot [MAXC], obs_x [MAXC], obs_y [MAXC], obs_col [MAXC];
  int exp_end;
  int first_c, fx, fy, lx, ly, cnt, done_c, dcnt;
  typedef struct {
    int sel; int pl; logic [2:0] col;
    int fx; int fy; int lx; int ly; int plots; int done_c;
  } vec_t;
  vec_t vecs [4];

  box_sequence_plotter dut (
    .clk(clk), .resetn(resetn), .start(start_d), .player(player[0:0]), .colour_in(colour_in),
    .stall(stall), .busy(d_busy), .done(d_done), .x(d_x), .y(d_y), .colour(d_colour), .plot(d_plot));
  // Wide pitch pushes lane 1 onto the right screen edge; three lanes give an unused player code.
  box_sequence_plotter #(.NUM_PLAYERS(3), .PLAYER_PITCH(121)) dut_c (
    .clk(clk), .resetn(resetn), .start(start_c), .player(player), .colour_in(colour_in),
    .stall(stall), .busy(c_busy), .done(c_done), .x(c_x), .y(c_y), .colour(c_colour), .plot(c_plot));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin sarr[i] = 0; starr[i] = 0; end
    starr[0] = 1;
  endtask

  task automatic model(input int pitch, input int pl);
    int c;
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_plot[i] = 0; exp_xy[i] = 0; exp_x[i] = 0; exp_y[i] = 0;
    end
    c = 1;
    for (int i = 0; i < 33; i++) begin
      exp_busy[c] = 1;
      c++;
      for (int py = 0; py < 2; py++) begin
        for (int px = 0; px < 2; px++) begin
          int xx, yy, vis;
          xx = 38 + pl * pitch + ((i >= 17) ? 5 : 0) + px;
          yy = YT[i] + py;
          vis = (xx < 160 && yy < 120) ? 1 : 0;
          while (sarr[c] && c < MAXC - 3) begin
            exp_busy[c] = 1; exp_xy[c] = vis; exp_x[c] = xx; exp_y[c] = yy;
            c++;
          end
          exp_busy[c] = 1; exp_plot[c] = vis; exp_xy[c] = vis; exp_x[c] = xx; exp_y[c] = yy;
          c++;
        end
      end
    end
    exp_busy[c] = 1; exp_done[c] = 1;
    exp_end = c;
  endtask

  task automatic capture(input int sel, input int pl, input logic [2:0] col, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      stall = sarr[c];
      start_d = (sel == 0) && starr[c];
      start_c = (sel == 1) && starr[c];
      player = 2'(pl);
      colour_in = col;
      @(negedge clk);
      obs_busy[c] = sel ? int'(c_busy) : int'(d_busy);
      obs_done[c] = sel ? int'(c_done) : int'(d_done);
      obs_plot[c] = sel ? int'(c_plot) : int'(d_plot);
      obs_x[c] = sel ? int'(c_x) : int'(d_x);
      obs_y[c] = sel ? int'(c_y) : int'(d_y);
      obs_col[c] = sel ? int'(c_colour) : int'(d_colour);
    end
    @(posedge clk); #1;
    stall = 0; start_d = 0; start_c = 0;
  endtask

  task automatic check_trace(input string nm, input logic [2:0] col, input int n);
    for (int c = 0; c < n; c++) begin
      chk({nm, ".busy"}, c, obs_busy[c], exp_busy[c]);
      chk({nm, ".done"}, c, obs_done[c], exp_done[c]);
      chk({nm, ".plot"}, c, obs_plot[c], exp_plot[c]);
      if (exp_xy[c] != 0) begin
        chk({nm, ".x"}, c, obs_x[c], exp_x[c] & 255);
        chk({nm, ".y"}, c, obs_y[c], exp_y[c] & 127);
      end
      if (exp_plot[c] != 0) chk({nm, ".colour"}, c, obs_col[c], int'(col));
    end
  endtask

  task automatic summarize(input int n);
    first_c = -1; fx = -1; fy = -1; lx = -1; ly = -1; cnt = 0; done_c = -1; dcnt = 0;
    for (int c = 0; c < n; c++) begin
      if (obs_plot[c] != 0) begin
        if (first_c < 0) begin first_c = c; fx = obs_x[c]; fy = obs_y[c]; end
        lx = obs_x[c]; ly = obs_y[c]; cnt++;
      end
      if (obs_done[c] != 0) begin
        if (done_c < 0) done_c = c;
        dcnt++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 3'b100, 38, 4, 44, 101, 132, 166};
    vecs[1] = '{0, 1, 3'b111, 118, 4, 124, 101, 132, 166};
    vecs[2] = '{1, 1, 3'b010, 159, 4, 159, 98, 34, 166};
    vecs[3] = '{1, 0, 3'b000, 38, 4, 44, 101, 132, 166};

    @(negedge clk);
    chk("rst.busy", 0, int'(d_busy), 0); chk("rst.done", 0, int'(d_done), 0);
    chk("rst.plot", 0, int'(d_plot), 0); chk("rst.x", 0, int'(d_x), 0);
    chk("rst.y", 0, int'(d_y), 0); chk("rst.colour", 0, int'(d_colour), 0);
    chk("rst_c.busy", 0, int'(c_busy), 0); chk("rst_c.plot", 0, int'(c_plot), 0);
    @(posedge clk); #1 resetn = 1;

    for (int v = 0; v < 4; v++) begin
      clear_stim();
      model(vecs[v].sel ? 121 : 80, vecs[v].pl);
      capture(vecs[v].sel, vecs[v].pl, vecs[v].col, exp_end + 2);
      check_trace($sformatf("vec%0d", v), vecs[v].col, exp_end + 2);
      summarize(exp_end + 2);
      chk($sformatf("vec%0d.first_cycle", v), 0, first_c, 2);
      chk($sformatf("vec%0d.first_x", v), 0, fx, vecs[v].fx);
      chk($sformatf("vec%0d.first_y", v), 0, fy, vecs[v].fy);
      chk($sformatf("vec%0d.last_x", v), 0, lx, vecs[v].lx);
      chk($sformatf("vec%0d.last_y", v), 0, ly, vecs[v].ly);
      chk($sformatf("vec%0d.plots", v), 0, cnt, vecs[v].plots);
      chk($sformatf("vec%0d.done_cycle", v), 0, done_c, vecs[v].done_c);
    end

    clear_stim();
    sarr[3] = 1; sarr[4] = 1; sarr[5] = 1;
    model(80, 0);
    capture(0, 0, 3'b100, exp_end + 2);
    check_trace("stall3", 3'b100, exp_end + 2);
    for (int c = 3; c <= 5; c++) begin
      chk("stall3.hold_plot", c, obs_plot[c], 0);
      chk("stall3.hold_x", c, obs_x[c], 39);
      chk("stall3.hold_y", c, obs_y[c], 4);
    end
    chk("stall3.resume_plot", 6, obs_plot[6], 1);
    chk("stall3.resume_x", 6, obs_x[6], 39);
    summarize(exp_end + 2);
    chk("stall3.done_cycle", 0, done_c, 169);

    clear_stim();
    starr[50] = 1; starr[166] = 1;
    model(80, 1);
    capture(0, 1, 3'b111, exp_end + 3);
    check_trace("busy_start", 3'b111, exp_end + 3);
    summarize(exp_end + 3);
    chk("busy_start.done_pulses", 0, dcnt, 1);

    @(posedge clk); #1;
    start_c = 1; player = 2'd3; colour_in = 3'b111;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 start_c = 0;
      @(negedge clk);
      chk("bad_player.busy", c, int'(c_busy), 0);
      chk("bad_player.done", c, int'(c_done), 0);
    end

    @(posedge clk); #1;
    start_d = 1; player = 2'd0; colour_in = 3'b100; stall = 0;
    for (int c = 1; c <= 50; c++) begin @(posedge clk); #1 start_d = 0; end
    chk("abort.pre_plot", 50, int'(d_plot), 1);
    chk("abort.pre_y", 50, int'(d_y), 62);
    resetn = 0;
    #1;
    chk("abort.plot", 50, int'(d_plot), 0);
    chk("abort.busy", 50, int'(d_busy), 0);
    chk("abort.done", 50, int'(d_done), 0);
    @(posedge clk); #1;
    chk("abort.hold_busy", 51, int'(d_busy), 0);
    resetn = 1;
    clear_stim();
    model(80, 0);
    capture(0, 0, 3'b001, exp_end + 2);
    check_trace("after_abort", 3'b001, exp_end + 2);
    summarize(exp_end + 2);
    chk("after_abort.first_y", 0, fy, 4);

    for (int r = 0; r < 6; r++) begin
      int sel, pl;
      logic [2:0] col;
      sel = r % 2;
      pl = int'($urandom_range(0, sel ? 2 : 1));
      col = 3'($urandom);
      clear_stim();
      for (int c = 1; c < 400; c++) sarr[c] = ($urandom_range(0, 99) < 25);
      model(sel ? 121 : 80, pl);
      for (int c = 1; c <= exp_end; c++) starr[c] = ($urandom_range(0, 19) == 0);
      capture(sel, pl, col, exp_end + 2);
      check_trace($sformatf("rand%0d", r), col, exp_end + 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
